// File: rtl/logic_pipe_pkg.sv
// Shared opcode encoding and popcount helper for the bitwise logic pipeline.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package logic_pipe_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_XNOR = 3'b011,
        OP_NAND = 3'b100,
        OP_NOR  = 3'b101,
        OP_NOTA = 3'b110,
        OP_RSVD = 3'b111
    } op_e;

    // Callers zero-extend their operand to POP_MAX_W; unused upper bits fold away.
    localparam int POP_MAX_W = 1024;
    localparam int POP_CNT_W = $clog2(POP_MAX_W + 1);

    function automatic logic [POP_CNT_W-1:0] popcount(input logic [POP_MAX_W-1:0] v);
        logic [POP_CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            n = n + POP_CNT_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/logic_op_core.sv
// Combinational WIDTH-bit logic op with equality, popcount and illegal-op flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the surrounding pipeline owns all flow control.
module logic_op_core
    import logic_pipe_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int ONES_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [2:0]        op,
    output logic [WIDTH-1:0]  res,
    output logic              eq,
    output logic [ONES_W-1:0] ones,
    output logic              err
);

    logic [POP_MAX_W-1:0] res_ext;

    always_comb begin
        res     = '0;
        err     = 1'b0;
        res_ext = '0;
        case (op_e'(op))
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_XNOR: res = a ~^ b;
            OP_NAND: res = ~(a & b);
            OP_NOR:  res = ~(a | b);
            OP_NOTA: res = ~a;
            default: begin
                res = '0;
                err = 1'b1;
            end
        endcase
        eq                   = &(a ~^ b);
        res_ext[WIDTH-1:0]   = res;
        ones                 = ONES_W'(popcount(res_ext));
    end

endmodule

// File: rtl/param_logic_pipe.sv
// Two-stage valid/ready pipelined bitwise logic unit with a handoff counter.
// Latency: 2 cycles from input transfer to out_valid; 1 op/cycle sustained.
// Backpressure: S2 holds on out_valid && !out_ready, S1 fills once, then in_ready drops.
module param_logic_pipe
    import logic_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_a,
    input  logic [WIDTH-1:0]             in_b,
    input  logic [2:0]                   in_op,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_res,
    output logic                         out_eq,
    output logic [$clog2(WIDTH+1)-1:0]   out_ones,
    output logic                         out_err,
    output logic [CNT_W-1:0]             op_count
);

    localparam int ONES_W = $clog2(WIDTH + 1);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [2:0]       s1_op;

    logic              s2_adv;
    logic              in_xfer;
    logic              out_xfer;
    logic [WIDTH-1:0]  c_res;
    logic              c_eq;
    logic [ONES_W-1:0] c_ones;
    logic              c_err;

    // in_ready is a function of pipeline state and out_ready only, never in_valid.
    assign s2_adv   = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || s2_adv;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
        end else begin
            if (in_xfer) begin
                s1_valid <= 1'b1;
                s1_a     <= in_a;
                s1_b     <= in_b;
                s1_op    <= in_op;
            end else if (s2_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

    logic_op_core #(
        .WIDTH  (WIDTH),
        .ONES_W (ONES_W)
    ) u_core (
        .a    (s1_a),
        .b    (s1_b),
        .op   (s1_op),
        .res  (c_res),
        .eq   (c_eq),
        .ones (c_ones),
        .err  (c_err)
    );

    // A refill in the same cycle as a handoff overwrites S2 with no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_res   <= '0;
            out_eq    <= 1'b0;
            out_ones  <= '0;
            out_err   <= 1'b0;
        end else begin
            if (s2_adv) begin
                out_valid <= 1'b1;
                out_res   <= c_res;
                out_eq    <= c_eq;
                out_ones  <= c_ones;
                out_err   <= c_err;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (out_xfer) begin
            op_count <= op_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_param_logic_pipe.sv
// Directed bench for param_logic_pipe: default build, CNT_W=2 build and WIDTH=1 build.
module tb_param_logic_pipe;

    logic clk;
    logic rst_n;
    logic in_valid;
    logic out_ready;
    logic [2:0] in_op;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [0:0] a1;
    logic [0:0] b1;

    logic        ir8, ov8, eq8, err8;
    logic [7:0]  res8;
    logic [3:0]  ones8;
    logic [15:0] cnt8;

    logic        ir2, ov2, eq2, err2;
    logic [7:0]  res2;
    logic [3:0]  ones2;
    logic [1:0]  cnt2;

    logic        ir1, ov1, eq1, err1;
    logic [0:0]  res1;
    logic [0:0]  ones1;
    logic [15:0] cnt1;

    int checks;
    int errors;

    param_logic_pipe #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir8),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(ov8),
        .out_ready(out_ready), .out_res(res8), .out_eq(eq8),
        .out_ones(ones8), .out_err(err8), .op_count(cnt8)
    );

    param_logic_pipe #(.WIDTH(8), .CNT_W(2)) dut_c2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir2),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(ov2),
        .out_ready(out_ready), .out_res(res2), .out_eq(eq2),
        .out_ones(ones2), .out_err(err2), .op_count(cnt2)
    );

    param_logic_pipe #(.WIDTH(1), .CNT_W(16)) dut_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1),
        .in_a(a1), .in_b(b1), .in_op(in_op), .out_valid(ov1),
        .out_ready(out_ready), .out_res(res1), .out_eq(eq1),
        .out_ones(ones1), .out_err(err1), .op_count(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    logic [7:0] exp_res [8];
    logic [3:0] exp_ones [8];
    logic [0:0] exp_w1 [4];

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_op     = 3'd0;
        in_a      = 8'h00;
        in_b      = 8'h00;
        a1        = 1'b0;
        b1        = 1'b0;
        exp_res   = '{8'hAA, 8'hAA, 8'h00, 8'hFF, 8'h55, 8'h55, 8'h55, 8'h00};
        exp_ones  = '{4'd4, 4'd4, 4'd0, 4'd8, 4'd4, 4'd4, 4'd4, 4'd0};
        exp_w1    = '{1'b0, 1'b1, 1'b1, 1'b0};

        // Reset state
        step();
        step();
        chk("rst_out_valid", 32'(ov8), 32'd0);
        chk("rst_out_res", 32'(res8), 32'd0);
        chk("rst_out_ones", 32'(ones8), 32'd0);
        chk("rst_out_eq_err", 32'({eq8, err8}), 32'd0);
        chk("rst_op_count", 32'(cnt8), 32'd0);
        rst_n = 1'b1;
        step();
        chk("rst_in_ready", 32'(ir8), 32'd1);

        // Single XNOR op
        in_valid = 1'b1; in_a = 8'hF0; in_b = 8'hCC; in_op = 3'b011;
        step();
        in_valid = 1'b0;
        chk("single_s1_only", 32'(ov8), 32'd0);
        step();
        chk("single_valid", 32'(ov8), 32'd1);
        chk("single_res", 32'(res8), 32'hC3);
        chk("single_eq", 32'(eq8), 32'd0);
        chk("single_ones", 32'(ones8), 32'd4);
        chk("single_err", 32'(err8), 32'd0);
        step();
        chk("single_count", 32'(cnt8), 32'd1);
        chk("single_drained", 32'(ov8), 32'd0);

        // Opcode sweep, back-to-back; CNT_W=2 copy checks wrap 0,1,2,3,0,1
        do_reset();
        in_valid = 1'b1; in_a = 8'hAA; in_b = 8'hAA;
        for (int i = 0; i < 8; i++) begin
            in_op = 3'(i);
            chk($sformatf("sweep_in_ready_%0d", i), 32'(ir8), 32'd1);
            step();
            if (i > 0) begin
                chk($sformatf("sweep_valid_%0d", i - 1), 32'(ov8), 32'd1);
                chk($sformatf("sweep_res_%0d", i - 1), 32'(res8), 32'(exp_res[i-1]));
                chk($sformatf("sweep_ones_%0d", i - 1), 32'(ones8), 32'(exp_ones[i-1]));
                chk($sformatf("sweep_eq_%0d", i - 1), 32'(eq8), 32'd1);
                chk($sformatf("sweep_err_%0d", i - 1), 32'(err8), 32'd0);
                chk($sformatf("sweep_count_%0d", i - 1), 32'(cnt8), 32'(i - 1));
                chk($sformatf("wrap_count_%0d", i - 1), 32'(cnt2), 32'((i - 1) % 4));
            end
        end
        in_valid = 1'b0;
        step();
        chk("sweep_valid_7", 32'(ov8), 32'd1);
        chk("sweep_res_7", 32'(res8), 32'h00);
        chk("sweep_err_7", 32'(err8), 32'd1);
        step();
        chk("sweep_count_final", 32'(cnt8), 32'd8);
        chk("wrap_count_final", 32'(cnt2), 32'd0);
        chk("sweep_drained", 32'(ov8), 32'd0);

        // Backpressure: out_ready low for 5 edges while streaming 4 ORs (res = a)
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 3'b001; in_b = 8'h00; in_a = 8'h01;
        step();
        chk("bp_ready_after1", 32'(ir8), 32'd1);
        chk("bp_valid_after1", 32'(ov8), 32'd0);
        in_a = 8'h02;
        step();
        chk("bp_ready_after2", 32'(ir8), 32'd0);
        chk("bp_valid_after2", 32'(ov8), 32'd1);
        chk("bp_res_after2", 32'(res8), 32'h01);
        in_a = 8'h03;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("bp_hold_ready_%0d", k), 32'(ir8), 32'd0);
            chk($sformatf("bp_hold_res_%0d", k), 32'(res8), 32'h01);
            chk($sformatf("bp_hold_valid_%0d", k), 32'(ov8), 32'd1);
        end
        chk("bp_hold_count", 32'(cnt8), 32'd8);
        out_ready = 1'b1;
        step();
        chk("bp_rel_res_2", 32'(res8), 32'h02);
        chk("bp_rel_ready", 32'(ir8), 32'd1);
        in_a = 8'h04;
        step();
        in_valid = 1'b0;
        chk("bp_rel_res_3", 32'(res8), 32'h03);
        step();
        chk("bp_rel_res_4", 32'(res8), 32'h04);
        chk("bp_rel_valid_4", 32'(ov8), 32'd1);
        step();
        chk("bp_drained", 32'(ov8), 32'd0);
        chk("bp_count", 32'(cnt8), 32'd12);

        // Reset mid-stream with two ops in flight
        in_valid = 1'b1; in_op = 3'b000; in_a = 8'hFF; in_b = 8'h0F;
        step();
        in_a = 8'hF0;
        step();
        in_valid = 1'b0;
        chk("mid_pre_valid", 32'(ov8), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_async_valid", 32'(ov8), 32'd0);
        chk("mid_async_count", 32'(cnt8), 32'd0);
        chk("mid_async_res", 32'(res8), 32'd0);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("mid_no_stale_%0d", k), 32'(ov8), 32'd0);
        end
        chk("mid_post_count", 32'(cnt8), 32'd0);

        // WIDTH=1 build: a=1, b=0 through AND/OR/XOR/XNOR
        a1 = 1'b1; b1 = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_op = 3'(i);
            step();
            if (i > 0) begin
                chk($sformatf("w1_res_%0d", i - 1), 32'(res1), 32'(exp_w1[i-1]));
                chk($sformatf("w1_ones_%0d", i - 1), 32'(ones1), 32'(exp_w1[i-1]));
                chk($sformatf("w1_valid_%0d", i - 1), 32'(ov1), 32'd1);
            end
        end
        in_valid = 1'b0;
        step();
        chk("w1_res_3", 32'(res1), 32'(exp_w1[3]));
        chk("w1_ones_3", 32'(ones1), 32'(exp_w1[3]));
        in_op = 3'b110;
        a1 = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("w1_nota_res", 32'(res1), 32'd1);
        chk("w1_nota_ones", 32'(ones1), 32'd1);
        step();
        chk("w1_count", 32'(cnt1), 32'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
